// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state type and idle-word default for the SPI TX feeder
package spi_pkg;

    // Transfer sequencer: wait for busy to rise, load one word, wait for busy to fall
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        LOAD      = 2'd1,
        WAIT_FALL = 2'd2
    } spi_state_e;

    // Word presented to the SPI slave when the FIFO has nothing to send
    localparam logic [7:0] SPI_IDLE_WORD = 8'hFF;

endpackage

// File: rtl/spi_tx_feeder_if.sv
// rtl/spi_tx_feeder_if.sv - host write port and SPI slave load port of the TX feeder
interface spi_tx_feeder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             full;
    logic [LW-1:0]    level;
    logic             spi_busy;
    logic [WIDTH-1:0] spi_data_in;
    logic             spi_data_in_valid;
    logic             intr;
    logic             underflow;
    logic             overflow;
    logic             clr_err;

    // Host / SPI-slave side that drives the feeder
    modport master (
        output wr_data, wr_en, spi_busy, clr_err,
        input  full, level, spi_data_in, spi_data_in_valid, intr, underflow, overflow
    );

    // The feeder itself
    modport slave (
        input  wr_data, wr_en, spi_busy, clr_err,
        output full, level, spi_data_in, spi_data_in_valid, intr, underflow, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock registered FIFO, head word visible without read-through
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [$clog2(DEPTH):0]     o_level_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [LW-1:0]    w_level_next;

    // Pointers carry one extra wrap bit so full and empty differ only in that MSB
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_wr_acc = i_wr_en && !o_full;
    assign w_rd_acc = i_rd_en && !o_empty;

    // Head word comes straight from storage, so a same-cycle write never appears here
    assign o_rd_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level      = r_level;
    assign o_level_next = w_level_next;

    // Occupancy after this cycle's accepted write and read
    always_comb begin
        w_level_next = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Storage array write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            r_level <= w_level_next;
        end
    end
endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - FIFO-backed word feeder that loads one word per SPI busy cycle
module spi_tx_feeder
    import spi_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(SPI_IDLE_WORD),
    parameter int               LOW_MARK  = 4
) (
    input  logic           clk,
    input  logic           rst,
    spi_tx_feeder_if.slave bus
);
    localparam int            LW         = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LOW_MARK_L = LW'(LOW_MARK);

    logic [2:0]       r_bsync;
    spi_state_e       r_state;
    spi_state_e       w_state_next;
    logic [WIDTH-1:0] r_data;
    logic             r_intr;
    logic             r_underflow;
    logic             r_overflow;

    logic             w_rise;
    logic             w_fall;
    logic             w_start;
    logic             w_pop;
    logic             w_valid;
    logic             w_uflow_set;
    logic             w_oflow_set;
    logic [WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [LW-1:0]    w_level;
    logic [LW-1:0]    w_level_next;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (bus.wr_en),
        .i_wr_data    (bus.wr_data),
        .i_rd_en      (w_pop),
        .o_rd_data    (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_level      (w_level),
        .o_level_next (w_level_next)
    );

    // Edges are taken from the two oldest synchronizer stages, away from metastability
    assign w_rise = (r_bsync[2:1] == 2'b01);
    assign w_fall = (r_bsync[2:1] == 2'b10);

    // Only a rise seen while idle starts a transfer, so a rise during LOAD/WAIT_FALL never pops
    assign w_start     = (r_state == WAIT_RISE) && w_rise;
    assign w_pop       = w_start && !w_empty;
    assign w_uflow_set = w_start && w_empty;
    // A write while full is dropped even if a pop frees a slot in the same cycle
    assign w_oflow_set = bus.wr_en && w_full;

    // Bring the asynchronous busy line into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bsync <= '0;
        end else begin
            r_bsync <= {r_bsync[1:0], bus.spi_busy};
        end
    end

    // Transfer sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_RISE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transfer sequencer next state and load strobe
    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        case (r_state)
            WAIT_RISE: begin
                if (w_rise) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_valid      = 1'b1;
                w_state_next = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (w_fall) begin
                    w_state_next = WAIT_RISE;
                end
            end
            default: begin
                w_state_next = WAIT_RISE;
            end
        endcase
    end

    // Output word register, changes only when a transfer starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= IDLE_WORD;
        end else if (w_start) begin
            r_data <= w_pop ? w_head : IDLE_WORD;
        end
    end

    // Low-level interrupt follows the occupancy this cycle leaves behind
    always_ff @(posedge clk) begin
        if (rst) begin
            r_intr <= 1'b1;
        end else begin
            r_intr <= (w_level_next <= LOW_MARK_L);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_uflow_set) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
            if (w_oflow_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.full              = w_full;
    assign bus.level             = w_level;
    assign bus.spi_data_in       = r_data;
    assign bus.spi_data_in_valid = w_valid;
    assign bus.intr              = r_intr;
    assign bus.underflow         = r_underflow;
    assign bus.overflow          = r_overflow;
endmodule

// File: doc/spi_tx_feeder.md
SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, SPI word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter IDLE_WORD, default 8'hFF, word sent on underflow.
REQ-004 SHALL have parameter LOW_MARK, default 4, level at or below which intr asserts.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_data, input, WIDTH bits: word to enqueue.
REQ-008 SHALL have port wr_en, input, 1 bit: enqueue strobe.
REQ-009 SHALL have port full, output, 1 bit: FIFO holds DEPTH words.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-011 SHALL have port spi_busy, input, 1 bit: SPI slave busy, asynchronous to clk.
REQ-012 SHALL have port spi_data_in, output, WIDTH bits: word presented to the SPI slave.
REQ-013 SHALL have port spi_data_in_valid, output, 1 bit: one-cycle load strobe to the SPI slave.
REQ-014 SHALL have port intr, output, 1 bit: low-level interrupt to the host.
REQ-015 SHALL have ports underflow and overflow, outputs, 1 bit each: sticky error flags.
REQ-016 SHALL have port clr_err, input, 1 bit: clears both sticky flags.

Function
REQ-017 SHALL pass spi_busy through a 3-flop synchronizer bsync[2:0]; rise = (bsync[2:1]==2'b01), fall = (bsync[2:1]==2'b10).
REQ-018 SHALL implement an FSM with states WAIT_RISE, LOAD, WAIT_FALL.
REQ-019 SHALL move WAIT_RISE->LOAD on rise, LOAD->WAIT_FALL unconditionally after one cycle, and WAIT_FALL->WAIT_RISE on fall; all other cases hold state.
REQ-020 SHALL, on the WAIT_RISE->LOAD transition with level>0, pop the head word into spi_data_in.
REQ-021 SHALL, on that transition with level==0, load IDLE_WORD into spi_data_in and set underflow.
REQ-022 SHALL assert spi_data_in_valid exactly during LOAD: one cycle, one cycle after the rise cycle.
REQ-023 SHALL hold spi_data_in stable outside a LOAD transition.
REQ-024 SHALL accept wr_en when not full; level increments by one.
REQ-025 SHALL drop a wr_en issued while full (contents unchanged) and set overflow, including when a pop occurs in the same cycle.
REQ-026 SHALL, on simultaneous accepted write and pop, leave level unchanged and keep FIFO order.
REQ-027 SHALL, on a write into an empty FIFO coinciding with a pop, send IDLE_WORD (no bypass) and enqueue the written word.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL derive full from the pointer MSB comparison.
REQ-030 SHALL register intr = (level <= LOW_MARK) from the post-update level, one cycle latency.
REQ-031 SHALL clear underflow and overflow with clr_err; a set event in the same cycle wins.
REQ-032 SHALL ignore a rise seen in LOAD or WAIT_FALL (no double pop).

Reset
REQ-033 SHALL reset FSM to WAIT_RISE and bsync, both pointers, level and full to 0.
REQ-034 SHALL reset spi_data_in to IDLE_WORD, spi_data_in_valid to 0, underflow and overflow to 0, and intr to 1.
REQ-035 SHALL abort any transfer on reset mid-operation with no pop and no valid pulse.

Structure
REQ-036 SHALL place the FSM state enum and IDLE_WORD default in shared package spi_pkg.
REQ-037 SHALL implement storage in sub-module sync_fifo (WIDTH, DEPTH): registered, single clock, no read-through.

Verification
REQ-038 SHALL cover: write A5,3C; pulse spi_busy high for 10 cycles twice -> valid pulses at rise+3 carrying A5 then 3C; level 2->0.
REQ-039 SHALL cover: empty FIFO, busy rise -> spi_data_in=FF, valid pulse, underflow=1; clr_err -> underflow=0.
REQ-040 SHALL cover: 17 writes, DEPTH=16 -> full=1, level=16, overflow=1, 17th word never transmitted.
REQ-041 SHALL cover: 20 write/pop cycles crossing pointer wrap -> output order equals input order.
REQ-042 SHALL cover: spi_busy glitches high for 1 cycle during WAIT_FALL -> no extra pop; level=3 -> intr=1 and stays 1 with LOW_MARK=4.
REQ-043 SHALL cover: rst asserted in the cycle after rise -> no valid pulse, level=0, FSM in WAIT_RISE.
